// File: rtl/gpio_proto_pkg.sv
// rtl/gpio_proto_pkg.sv - GPO/GPI command protocol constants and FSM encodings
// Contents: opcode values, command-word field positions, main and issuer state types.
package gpio_proto_pkg;

    localparam int OPC_MSB     = 31;
    localparam int OPC_LSB     = 24;
    localparam int STB_BIT     = 23;
    localparam int PAYLOAD_MSB = 22;

    localparam logic [7:0] OP_RUN_LOG  = 8'h05;
    localparam logic [7:0] OP_STATUS   = 8'h0A;
    localparam logic [7:0] OP_ADDR_LOG = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_POLL,
        ST_READ,
        ST_OUT
    } main_state_t;

    typedef enum logic [1:0] {
        CS_IDLE,
        CS_SETUP,
        CS_STB,
        CS_WAIT
    } cmd_state_t;

endpackage

// File: rtl/gpio_cmd_issuer.sv
// rtl/gpio_cmd_issuer.sv - one GPO command transaction: SETUP, STB, WAIT, then sample GPI
// Ports: clk, i_rst (sync, active-high), i_req (start a transaction, accepted when o_idle),
//        i_opcode/i_payload (command fields), i_gpi (response bus),
//        o_gpo (command bus), o_rsp/o_rsp_valid (captured response, 1-cycle pulse), o_idle.
module gpio_cmd_issuer
    import gpio_proto_pkg::*;
#(
    parameter int NB_GPIOS   = 32,
    parameter int STB_CYCLES = 2,
    parameter int RSP_WAIT   = 4
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_req,
    input  logic [7:0]             i_opcode,
    input  logic [PAYLOAD_MSB:0]   i_payload,
    input  logic [NB_GPIOS-1:0]    i_gpi,
    output logic [NB_GPIOS-1:0]    o_gpo,
    output logic [NB_GPIOS-1:0]    o_rsp,
    output logic                   o_rsp_valid,
    output logic                   o_idle
);

    localparam int CNT_MAX = (STB_CYCLES > RSP_WAIT) ? STB_CYCLES : RSP_WAIT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    cmd_state_t      state;
    logic [CW-1:0]   cnt;

    assign o_idle = (state == CS_IDLE);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state       <= CS_IDLE;
            cnt         <= '0;
            o_gpo       <= '0;
            o_rsp       <= '0;
            o_rsp_valid <= 1'b0;
        end else begin
            o_rsp_valid <= 1'b0;
            case (state)
                CS_IDLE: begin
                    if (i_req) begin
                        o_gpo <= NB_GPIOS'({i_opcode, 1'b0, i_payload});
                        cnt   <= '0;
                        state <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    o_gpo[STB_BIT] <= 1'b1;
                    cnt            <= '0;
                    state          <= CS_STB;
                end
                CS_STB: begin
                    if (cnt == CW'(STB_CYCLES - 1)) begin
                        o_gpo[STB_BIT] <= 1'b0;
                        cnt            <= '0;
                        state          <= CS_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CS_WAIT: begin
                    // Capture on the edge that ends the last WAIT cycle; the bus
                    // is released on that same edge.
                    if (cnt == CW'(RSP_WAIT - 1)) begin
                        o_rsp       <= i_gpi;
                        o_rsp_valid <= 1'b1;
                        o_gpo       <= '0;
                        cnt         <= '0;
                        state       <= CS_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= CS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gpio_log_reader.sv
// rtl/gpio_log_reader.sv - arms the memory logger, polls for full, streams every log word out
// Ports: clk, i_rst (sync, active-high), i_start, i_abort, i_gpi (register-file response),
//        i_ready (downstream ready), o_gpo (command bus), o_data/o_valid/o_last (word stream),
//        o_busy, o_done (completion pulse), o_error (sticky poll timeout).
module gpio_log_reader
    import gpio_proto_pkg::*;
#(
    parameter int NB_GPIOS        = 32,
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int LOG_DEPTH       = 32768,
    parameter int STB_CYCLES      = 2,
    parameter int RSP_WAIT        = 4,
    parameter int POLL_MAX        = 1000000
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [NB_GPIOS-1:0]  i_gpi,
    input  logic                 i_ready,
    output logic [NB_GPIOS-1:0]  o_gpo,
    output logic [NB_GPIOS-1:0]  o_data,
    output logic                 o_valid,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error
);

    // One extra address bit so a full 2^BRAM_ADDR_WIDTH log ends without wrapping.
    localparam logic [BRAM_ADDR_WIDTH:0] LAST_ADDR = (BRAM_ADDR_WIDTH + 1)'(LOG_DEPTH - 1);

    main_state_t                 state;
    logic [BRAM_ADDR_WIDTH:0]    addr;
    logic [31:0]                 poll_cnt;
    logic                        waiting;     // a command has been requested and not answered
    logic                        abort_pend;  // abort seen mid-transaction, honoured at its end
    logic                        req;
    logic [7:0]                  opcode;
    logic [PAYLOAD_MSB:0]        payload;
    logic [NB_GPIOS-1:0]         gpo_int;
    logic [NB_GPIOS-1:0]         rsp;
    logic                        rsp_valid;
    logic                        iss_idle;

    always_comb begin
        opcode  = OP_STATUS;
        payload = '0;
        case (state)
            ST_RUN:  opcode = OP_RUN_LOG;
            ST_READ: begin
                opcode                           = OP_ADDR_LOG;
                payload[BRAM_ADDR_WIDTH-1:0]     = addr[BRAM_ADDR_WIDTH-1:0];
            end
            default: opcode = OP_STATUS;
        endcase
    end

    gpio_cmd_issuer #(
        .NB_GPIOS   (NB_GPIOS),
        .STB_CYCLES (STB_CYCLES),
        .RSP_WAIT   (RSP_WAIT)
    ) u_issuer (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_req       (req),
        .i_opcode    (opcode),
        .i_payload   (payload),
        .i_gpi       (i_gpi),
        .o_gpo       (gpo_int),
        .o_rsp       (rsp),
        .o_rsp_valid (rsp_valid),
        .o_idle      (iss_idle)
    );

    // Reset drops the strobe in the same cycle rather than waiting for the edge.
    assign o_gpo = i_rst ? '0 : gpo_int;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            addr       <= '0;
            poll_cnt   <= '0;
            waiting    <= 1'b0;
            abort_pend <= 1'b0;
            req        <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            req    <= 1'b0;
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        state      <= ST_RUN;
                        o_busy     <= 1'b1;
                        o_error    <= 1'b0;
                        poll_cnt   <= '0;
                        addr       <= '0;
                        waiting    <= 1'b0;
                        abort_pend <= 1'b0;
                    end
                end
                ST_RUN, ST_POLL, ST_READ: begin
                    if (!waiting) begin
                        if (i_abort || abort_pend) begin
                            state      <= ST_IDLE;
                            o_busy     <= 1'b0;
                            abort_pend <= 1'b0;
                        end else if (iss_idle) begin
                            req     <= 1'b1;
                            waiting <= 1'b1;
                        end
                    end else if (rsp_valid) begin
                        waiting <= 1'b0;
                        if (i_abort || abort_pend) begin
                            state      <= ST_IDLE;
                            o_busy     <= 1'b0;
                            abort_pend <= 1'b0;
                        end else begin
                            case (state)
                                ST_RUN: state <= ST_POLL;
                                ST_POLL: begin
                                    if (rsp[0]) begin
                                        state <= ST_READ;
                                        addr  <= '0;
                                    end else if (poll_cnt + 32'd1 >= 32'(POLL_MAX)) begin
                                        state   <= ST_IDLE;
                                        o_busy  <= 1'b0;
                                        o_error <= 1'b1;
                                    end else begin
                                        poll_cnt <= poll_cnt + 32'd1;
                                    end
                                end
                                default: begin
                                    o_data  <= rsp;
                                    o_valid <= 1'b1;
                                    o_last  <= (addr == LAST_ADDR);
                                    state   <= ST_OUT;
                                end
                            endcase
                        end
                    end else if (i_abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (i_abort) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        o_busy  <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        if (o_last) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= ST_READ;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
